// File: rtl/counter_seq_pkg.sv
// Shared types and defaults for the counter enable sequencer.
// Holds the FSM state encoding and the mode encodings used by the top level.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_CONT  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

    localparam int PRESCALE_W_DEF = 8;
    localparam int BURST_W_DEF    = 4;

endpackage

// File: rtl/enable_prescaler.sv
// Loadable down-counter that flags a tick whenever it reaches zero while running.
// It reloads itself on the tick, so the tick period is reload_val+1 cycles.
module enable_prescaler #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         run,
    input  logic [W-1:0] reload_val,
    output logic         tick
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= reload_val;
        end else if (run) begin
            if (count == '0) begin
                count <= reload_val;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign tick = run && (count == '0);

endmodule

// File: rtl/counter_enable_sequencer.sv
// Generates the clear and enable strobes for the downstream 4-bit counter,
// either as a continuous prescaled stream or as a finite burst.
module counter_enable_sequencer
    import counter_seq_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF,
    parameter int BURST_W    = BURST_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BURST_W-1:0]    burst_len,
    output logic                  enable_out,
    output logic                  counter_clr,
    output logic                  busy,
    output logic                  done,
    output state_t                dbg_state
);

    localparam logic [BURST_W:0] FULL_BURST = {1'b1, {BURST_W{1'b0}}};

    state_t                state;
    logic [PRESCALE_W-1:0] cfg_prescale;
    logic [BURST_W-1:0]    cfg_burst_len;
    logic                  cfg_mode;
    logic [BURST_W:0]      remaining;
    logic                  tick;
    logic                  pre_load;
    logic                  pre_run;

    // The divider is primed on the CLEAR->RUN edge and only counts while a run is live.
    assign pre_load = (state == CLEAR) && !stop;
    assign pre_run  = (state == RUN) && !stop;

    enable_prescaler #(
        .W(PRESCALE_W)
    ) u_prescaler (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (pre_load),
        .run       (pre_run),
        .reload_val(cfg_prescale),
        .tick      (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cfg_prescale  <= '0;
            cfg_burst_len <= '0;
            cfg_mode      <= MODE_CONT;
            remaining     <= '0;
            enable_out    <= 1'b0;
            counter_clr   <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    enable_out  <= 1'b0;
                    counter_clr <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    if (start && !stop) begin
                        cfg_prescale  <= prescale;
                        cfg_burst_len <= burst_len;
                        cfg_mode      <= mode;
                        counter_clr   <= 1'b1;
                        busy          <= 1'b1;
                        state         <= CLEAR;
                    end
                end
                CLEAR: begin
                    counter_clr <= 1'b0;
                    enable_out  <= 1'b0;
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        remaining <= (cfg_burst_len == '0) ? FULL_BURST
                                                           : {1'b0, cfg_burst_len};
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        enable_out <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (tick) begin
                        enable_out <= 1'b1;
                        if (cfg_mode == MODE_BURST) begin
                            remaining <= remaining - 1'b1;
                            if (remaining == {{BURST_W{1'b0}}, 1'b1}) begin
                                state <= DONE;
                            end
                        end
                    end else begin
                        enable_out <= 1'b0;
                    end
                end
                DONE: begin
                    // This cycle carries the final enable; the done pulse follows it.
                    enable_out <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule
